de_bad_detect_pipe: RTL and testbench
=====================================

# de_bad_detect_pipe

Registered, parametrised illegal-instruction detector for the Raisin64 decode stage. Checks up to `LANES` fetched instruction words per cycle against configurable reserved-opcode, 64-bit-only and FPU opcode sets, and classifies each word with a cause code. Uses a single valid/ready pipeline register between fetch and decode. Keeps a sticky first-fault capture and a saturating bad-instruction counter for the exception/debug unit.

## Interface
Parameters:
- `LANES`, 1 — instruction words checked per cycle (1..4).
- `CNT_W`, 16 — width of the bad-instruction counter.
- `BAD_MASK`, 64'h0000_080C_0FF0_080C — bit n set means 32/64-bit opcode n (instIn[61:56]) is reserved.
- `LONG_ONLY_MASK`, built from `OP_F*`, `OP_LUI`, `OP_JALI`, `OP_JI` — opcodes that are legal only in 64-bit form.
- `FPU_MASK`, built from `OP_F*` — opcodes that are illegal while `fpuEn`=0.

Ports:
- `clk` in 1 — single clock, rising edge.
- `rst_n` in 1 — asynchronous, active-low reset.
- `inValid` in 1 — input bundle valid.
- `inReady` out 1 — block accepts the bundle this cycle.
- `inLaneValid` in LANES — per-lane occupancy.
- `instIn` in 64*LANES — lane i is bits [64i+63:64i].
- `fpuEn` in 1 — FPU enabled, sampled on acceptance.
- `outValid` out 1 — output register holds a bundle.
- `outReady` in 1 — downstream accepts.
- `outLaneValid` out LANES — registered copy of `inLaneValid`.
- `instOut` out 64*LANES — registered instructions.
- `badOpcode` out LANES — per-lane illegal flag (0 for invalid lanes).
- `badCause` out 3*LANES — per-lane cause.
- `faultValid` out 1 — sticky: a fault has been captured.
- `faultInst` out 64 — first captured illegal word.
- `faultCause` out 3 — cause of the captured word.
- `faultClr` in 1 — clears the capture.
- `badCount` out CNT_W — saturating count of illegal lanes.

## Operation
- Format per lane: bit63=0 is 16-bit; [63:62]=2'b10 is 32-bit; [63:62]=2'b11 is 64-bit. Opcode `op` = [61:56].
- Cause codes: 0 NONE, 1 BAD16 (16-bit with [62:60]=3'h7), 2 RESERVED (`BAD_MASK[op]`), 3 NEEDS64 (32-bit form with `LONG_ONLY_MASK[op]`), 4 FPU_OFF (`FPU_MASK[op]` and `fpuEn`=0). Codes 5–7 are never produced.
- Priority for 32/64-bit words: RESERVED > NEEDS64 > FPU_OFF.
- A lane is bad when its cause is not 0. Invalid lanes are forced to cause 0.
- Acceptance: `acc = inValid & inReady`, where `inReady = ~outValid | outReady`. This gives full throughput with no bubble.
- On `acc`, the output register loads the instructions, lane-valid bits, flags and causes, and `outValid` is set.
- When `outValid & outReady` and there is no `acc`, `outValid` clears. Data is held stable while `outValid & ~outReady`.
- Capture: on `acc` with any bad lane while `faultValid`=0 (or `faultClr`=1 in the same cycle), capture the lowest-index bad lane's word and cause, and set `faultValid`. Otherwise `faultClr` clears `faultValid` only; `faultInst` and `faultCause` hold their values.
- Counter: on `acc`, `badCount += popcount(bad lanes)`, saturating at 2^CNT_W−1. There is no counter clear other than reset.

## Timing
- Latency: 1 cycle from acceptance to `outValid`, flags, causes and counter/capture update.
- `inReady` is combinational from `outValid` and `outReady` only. It has no path from `inValid`.
- Reset values: `outValid`=0, `outLaneValid`=0, `instOut`=0, `badOpcode`=0, `badCause`=0, `faultValid`=0, `faultInst`=0, `faultCause`=0, `badCount`=0.
- Reset asserted mid-transfer discards the held bundle immediately (asynchronous). The first acceptance is possible in the cycle after `rst_n` rises.
- Simultaneous capture and clear: the capture wins; `faultValid` stays 1 and holds the new word.
- Counter near saturation: the increment is clamped, never wraps.

## Structure
- Opcode constants (`OP_*`), format bit positions and cause encodings live in the shared `de_isa_def.vh`. The mask defaults are derived from those constants.
- Sub-module `de_bad_classify`: combinational single-lane classifier (instruction, fpuEn → cause). It is instantiated `LANES` times via generate.
- The top level holds the pipeline register, capture logic, popcount and saturating counter.

## Test plan
- LANES=1, 16-bit word 64'h7000_0000_0000_0000 → next cycle `badOpcode`=1, cause 1, `faultInst` equals the word, `badCount`=1.
- 32-bit `op`=6'h14 (64'h9400_...) and 64-bit `op`=6'h14 (64'hD400_...) → both cause 2. 32-bit `OP_LUI` → cause 3; 64-bit `OP_LUI` → cause 0.
- `OP_F*` in 64-bit form with `fpuEn`=0 → cause 4; with `fpuEn`=1 → cause 0.
- LANES=4, lanes {ok, bad16, reserved, invalid-but-bad} → `badOpcode`=4'b0110, capture holds lane 1, count +2.
- Hold `outReady`=0 for 3 cycles with `inValid`=1 → `inReady`=0, outputs stable, counter unchanged. Release → one transfer per cycle.
- CNT_W=2: six bad lanes → `badCount`=3. Bad word arriving with `faultClr` in the same cycle → new capture, `faultValid` stays 1. `rst_n` low mid-stream → all outputs 0 asynchronously.

Source files
------------

// File: rtl/de_bad_detect_pipe_pkg.sv
// Shared ISA definitions for the decode-stage illegal-instruction detector.
// Holds instruction format bit positions, opcode constants, cause codes and
// the default opcode masks derived from those constants.
package de_bad_detect_pipe_pkg;

  localparam int INST_W  = 64;
  localparam int CAUSE_W = 3;

  // Format decoding: bit 63 clear marks a 16-bit word; otherwise bit 62
  // selects 32-bit (0) or 64-bit (1). Opcode sits in [61:56].
  localparam int FMT_BIT = 63;
  localparam int LEN_BIT = 62;
  localparam int OP_MSB  = 61;
  localparam int OP_LSB  = 56;

  typedef enum logic [CAUSE_W-1:0] {
    CAUSE_NONE     = 3'd0,
    CAUSE_BAD16    = 3'd1,
    CAUSE_RESERVED = 3'd2,
    CAUSE_NEEDS64  = 3'd3,
    CAUSE_FPU_OFF  = 3'd4
  } cause_e;

  // Opcodes that are only meaningful in the 64-bit encoding.
  localparam logic [5:0] OP_JI   = 6'h30;
  localparam logic [5:0] OP_JALI = 6'h31;
  localparam logic [5:0] OP_LUI  = 6'h32;
  localparam logic [5:0] OP_FADD = 6'h38;
  localparam logic [5:0] OP_FSUB = 6'h39;
  localparam logic [5:0] OP_FMUL = 6'h3A;
  localparam logic [5:0] OP_FDIV = 6'h3B;

  localparam logic [63:0] BAD_MASK_DEF = 64'h0000_080C_0FF0_080C;

  localparam logic [63:0] FPU_MASK_DEF =
      (64'd1 << OP_FADD) | (64'd1 << OP_FSUB) |
      (64'd1 << OP_FMUL) | (64'd1 << OP_FDIV);

  localparam logic [63:0] LONG_ONLY_MASK_DEF =
      FPU_MASK_DEF | (64'd1 << OP_LUI) | (64'd1 << OP_JALI) | (64'd1 << OP_JI);

endpackage

// File: rtl/de_bad_classify.sv
// Combinational single-lane instruction classifier.
// Ports:
//   inst_hi_i  - instruction bits [63:56] (format bits + opcode)
//   fpu_en_i   - FPU enable
//   cause_o    - cause code (0 = legal)
module de_bad_classify
  import de_bad_detect_pipe_pkg::*;
#(
  parameter logic [63:0] BAD_MASK       = BAD_MASK_DEF,
  parameter logic [63:0] LONG_ONLY_MASK = LONG_ONLY_MASK_DEF,
  parameter logic [63:0] FPU_MASK       = FPU_MASK_DEF
) (
  input  logic [7:0]         inst_hi_i,
  input  logic               fpu_en_i,
  output logic [CAUSE_W-1:0] cause_o
);

  logic [5:0] op;
  cause_e     cause;

  assign op = inst_hi_i[5:0];

  // Checks are ordered so the highest-priority cause wins.
  always_comb begin
    cause = CAUSE_NONE;
    if (!inst_hi_i[FMT_BIT-56]) begin
      // 16-bit word: only the all-ones sub-format field is illegal.
      if (inst_hi_i[LEN_BIT-56 -: 3] == 3'h7) begin
        cause = CAUSE_BAD16;
      end
    end else if (BAD_MASK[op]) begin
      cause = CAUSE_RESERVED;
    end else if (!inst_hi_i[LEN_BIT-56] && LONG_ONLY_MASK[op]) begin
      cause = CAUSE_NEEDS64;
    end else if (FPU_MASK[op] && !fpu_en_i) begin
      cause = CAUSE_FPU_OFF;
    end
  end

  assign cause_o = cause;

endmodule

// File: rtl/de_bad_detect_pipe.sv
// Registered illegal-instruction detector for the decode stage.
// Classifies LANES instruction words per accepted bundle, registers them in
// a single valid/ready stage, captures the first faulting word and keeps a
// saturating count of illegal lanes.
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   inValid/inReady       - input handshake; inLaneValid per-lane occupancy
//   instIn, fpuEn         - instruction words and FPU enable
//   outValid/outReady     - output handshake
//   outLaneValid, instOut - registered lane-valid bits and words
//   badOpcode, badCause   - per-lane illegal flag and cause
//   faultValid/Inst/Cause - sticky first-fault capture; faultClr clears it
//   badCount              - saturating illegal-lane counter
module de_bad_detect_pipe
  import de_bad_detect_pipe_pkg::*;
#(
  parameter int          LANES          = 1,
  parameter int          CNT_W          = 16,
  parameter logic [63:0] BAD_MASK       = BAD_MASK_DEF,
  parameter logic [63:0] LONG_ONLY_MASK = LONG_ONLY_MASK_DEF,
  parameter logic [63:0] FPU_MASK       = FPU_MASK_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    inValid,
  output logic                    inReady,
  input  logic [LANES-1:0]        inLaneValid,
  input  logic [64*LANES-1:0]     instIn,
  input  logic                    fpuEn,
  output logic                    outValid,
  input  logic                    outReady,
  output logic [LANES-1:0]        outLaneValid,
  output logic [64*LANES-1:0]     instOut,
  output logic [LANES-1:0]        badOpcode,
  output logic [3*LANES-1:0]      badCause,
  output logic                    faultValid,
  output logic [63:0]             faultInst,
  output logic [2:0]              faultCause,
  input  logic                    faultClr,
  output logic [CNT_W-1:0]        badCount
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic                   acc;
  logic [3*LANES-1:0]     lane_cause;
  logic [LANES-1:0]       lane_bad;
  logic [63:0]            cap_inst;
  logic [2:0]             cap_cause;
  logic                   capture;
  logic [2:0]             bad_pop;
  logic [CNT_W+2:0]       cnt_sum;

  logic                   out_valid_q, out_valid_d;
  logic [LANES-1:0]       lane_valid_q, lane_valid_d;
  logic [64*LANES-1:0]    inst_q, inst_d;
  logic [LANES-1:0]       bad_q, bad_d;
  logic [3*LANES-1:0]     cause_q, cause_d;
  logic                   fault_valid_q, fault_valid_d;
  logic [63:0]            fault_inst_q, fault_inst_d;
  logic [2:0]             fault_cause_q, fault_cause_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  // Ready depends only on the output stage, never on inValid.
  assign inReady = ~out_valid_q | outReady;
  assign acc     = inValid & inReady;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [2:0] raw_cause;

    de_bad_classify #(
      .BAD_MASK       (BAD_MASK),
      .LONG_ONLY_MASK (LONG_ONLY_MASK),
      .FPU_MASK       (FPU_MASK)
    ) u_classify (
      .inst_hi_i (instIn[64*gi+56 +: 8]),
      .fpu_en_i  (fpuEn),
      .cause_o   (raw_cause)
    );

    // Empty lanes never report a fault, whatever their contents.
    assign lane_cause[3*gi +: 3] = inLaneValid[gi] ? raw_cause : 3'd0;
    assign lane_bad[gi]          = |raw_cause & inLaneValid[gi];
  end

  // Scan from the top lane down so the lowest-index bad lane ends up selected.
  always_comb begin
    cap_inst  = '0;
    cap_cause = '0;
    bad_pop   = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (lane_bad[i]) begin
        cap_inst  = instIn[64*i +: 64];
        cap_cause = lane_cause[3*i +: 3];
      end
      bad_pop = bad_pop + {2'b00, lane_bad[i]};
    end
  end

  // Extra headroom bits so the sum cannot wrap before the clamp.
  assign cnt_sum = {3'b000, cnt_q} + {{CNT_W{1'b0}}, bad_pop};

  assign capture = acc & (|lane_bad) & (~fault_valid_q | faultClr);

  always_comb begin
    out_valid_d   = out_valid_q;
    lane_valid_d  = lane_valid_q;
    inst_d        = inst_q;
    bad_d         = bad_q;
    cause_d       = cause_q;
    fault_valid_d = fault_valid_q;
    fault_inst_d  = fault_inst_q;
    fault_cause_d = fault_cause_q;
    cnt_d         = cnt_q;

    if (acc) begin
      out_valid_d  = 1'b1;
      lane_valid_d = inLaneValid;
      inst_d       = instIn;
      bad_d        = lane_bad;
      cause_d      = lane_cause;
      cnt_d        = (cnt_sum > {3'b000, CNT_MAX}) ? CNT_MAX : cnt_sum[CNT_W-1:0];
    end else if (outReady) begin
      out_valid_d = 1'b0;
    end

    // A new capture takes precedence over a clear in the same cycle.
    if (capture) begin
      fault_valid_d = 1'b1;
      fault_inst_d  = cap_inst;
      fault_cause_d = cap_cause;
    end else if (faultClr) begin
      fault_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q   <= 1'b0;
      lane_valid_q  <= '0;
      inst_q        <= '0;
      bad_q         <= '0;
      cause_q       <= '0;
      fault_valid_q <= 1'b0;
      fault_inst_q  <= '0;
      fault_cause_q <= '0;
      cnt_q         <= '0;
    end else begin
      out_valid_q   <= out_valid_d;
      lane_valid_q  <= lane_valid_d;
      inst_q        <= inst_d;
      bad_q         <= bad_d;
      cause_q       <= cause_d;
      fault_valid_q <= fault_valid_d;
      fault_inst_q  <= fault_inst_d;
      fault_cause_q <= fault_cause_d;
      cnt_q         <= cnt_d;
    end
  end

  assign outValid     = out_valid_q;
  assign outLaneValid = lane_valid_q;
  assign instOut      = inst_q;
  assign badOpcode    = bad_q;
  assign badCause     = cause_q;
  assign faultValid   = fault_valid_q;
  assign faultInst    = fault_inst_q;
  assign faultCause   = fault_cause_q;
  assign badCount     = cnt_q;

endmodule

// File: tb/tb_de_bad_detect_pipe.sv
module tb_de_bad_detect_pipe;
  import de_bad_detect_pipe_pkg::*;

  localparam int L  = 4;
  localparam int CW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic            in_valid, in_ready, fpu_en, out_valid, out_ready;
  logic            fault_valid, fault_clr;
  logic [L-1:0]    in_lv, out_lv, bad_op;
  logic [64*L-1:0] inst_in, inst_out;
  logic [3*L-1:0]  bad_cause;
  logic [63:0]     fault_inst;
  logic [2:0]      fault_cause;
  logic [CW-1:0]   bad_count;

  // Second instance: one lane, 2-bit counter for the saturation corner.
  logic        s_in_valid, s_in_ready, s_fpu_en, s_out_valid, s_out_ready;
  logic        s_in_lv, s_out_lv, s_bad_op, s_fault_valid, s_fault_clr;
  logic [63:0] s_inst_in, s_inst_out, s_fault_inst;
  logic [2:0]  s_bad_cause, s_fault_cause;
  logic [1:0]  s_bad_count;

  de_bad_detect_pipe #(.LANES(L), .CNT_W(CW)) u_dut (
    .clk(clk), .rst_n(rst_n), .inValid(in_valid), .inReady(in_ready),
    .inLaneValid(in_lv), .instIn(inst_in), .fpuEn(fpu_en),
    .outValid(out_valid), .outReady(out_ready), .outLaneValid(out_lv),
    .instOut(inst_out), .badOpcode(bad_op), .badCause(bad_cause),
    .faultValid(fault_valid), .faultInst(fault_inst), .faultCause(fault_cause),
    .faultClr(fault_clr), .badCount(bad_count)
  );

  de_bad_detect_pipe #(.LANES(1), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .inValid(s_in_valid), .inReady(s_in_ready),
    .inLaneValid(s_in_lv), .instIn(s_inst_in), .fpuEn(s_fpu_en),
    .outValid(s_out_valid), .outReady(s_out_ready), .outLaneValid(s_out_lv),
    .instOut(s_inst_out), .badOpcode(s_bad_op), .badCause(s_bad_cause),
    .faultValid(s_fault_valid), .faultInst(s_fault_inst), .faultCause(s_fault_cause),
    .faultClr(s_fault_clr), .badCount(s_bad_count)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state (what the output stage should hold).
  logic            m_valid;
  logic [L-1:0]    m_lv, m_bad;
  logic [64*L-1:0] m_inst;
  logic [3*L-1:0]  m_cause;
  logic            m_fv;
  logic [63:0]     m_finst;
  logic [2:0]      m_fcause;
  int              m_cnt;

  typedef struct {
    logic [63:0] inst;
    logic        fpu;
    logic [2:0]  cause;
  } vec_t;
  vec_t vt[12];

  int          cnt_before;
  logic [63:0] w_a, w_b, w_c, w_d;
  logic [255:0] held;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Cause derived directly from the ISA rules, by opcode membership.
  function automatic int ref_cause(input logic [63:0] w, input logic fpu);
    logic [5:0] op;
    op = w[61:56];
    if (!w[63]) return (w[62:60] == 3'b111) ? 1 : 0;
    if (op inside {6'd2, 6'd3, 6'd11, [6'd20:6'd27], 6'd34, 6'd35, 6'd43}) return 2;
    if (!w[62] && (op inside {OP_LUI, OP_JALI, OP_JI, OP_FADD, OP_FSUB, OP_FMUL, OP_FDIV}))
      return 3;
    if (!fpu && (op inside {OP_FADD, OP_FSUB, OP_FMUL, OP_FDIV})) return 4;
    return 0;
  endfunction

  function automatic logic [63:0] rand_word();
    logic [63:0] w;
    w = {$urandom, $urandom};
    case ($urandom_range(0, 6))
      0: w[61:56] = OP_LUI;
      1: w[61:56] = OP_FADD;
      2: w[61:56] = OP_FDIV;
      3: w[61:56] = 6'h14;
      4: w[61:56] = OP_JI;
      default: ;
    endcase
    return w;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_lv = '0; m_bad = '0; m_inst = '0; m_cause = '0;
    m_fv = 0; m_finst = '0; m_fcause = '0; m_cnt = 0;
  endtask

  task automatic model_edge();
    bit acc, cap_done;
    int c;
    logic [63:0] w;
    acc = in_valid && (!m_valid || out_ready);
    cap_done = 0;
    if (acc) begin
      m_valid = 1; m_lv = in_lv; m_inst = inst_in; m_bad = '0; m_cause = '0;
      for (int i = 0; i < L; i++) begin
        w = inst_in[64*i +: 64];
        c = in_lv[i] ? ref_cause(w, fpu_en) : 0;
        m_cause[3*i +: 3] = 3'(c);
        if (c != 0) begin
          m_bad[i] = 1'b1;
          m_cnt = (m_cnt + 1 > 65535) ? 65535 : m_cnt + 1;
          if (!cap_done && (!m_fv || fault_clr)) begin
            m_finst = w; m_fcause = 3'(c); cap_done = 1;
          end
        end
      end
    end else if (out_ready) begin
      m_valid = 0;
    end
    if (cap_done) m_fv = 1;
    else if (fault_clr) m_fv = 0;
  endtask

  task automatic compare_all(input string tag);
    check({tag, "_outValid"}, out_valid, m_valid);
    check({tag, "_outLaneValid"}, out_lv, m_lv);
    check({tag, "_instOut"}, inst_out, m_inst);
    check({tag, "_badOpcode"}, bad_op, m_bad);
    check({tag, "_badCause"}, bad_cause, m_cause);
    check({tag, "_faultValid"}, fault_valid, m_fv);
    check({tag, "_faultInst"}, fault_inst, m_finst);
    check({tag, "_faultCause"}, fault_cause, m_fcause);
    check({tag, "_badCount"}, bad_count, 256'(m_cnt));
  endtask

  // Called at posedge+1 with inputs already driven.
  task automatic step(input string tag);
    #2;
    check({tag, "_inReady"}, in_ready, (!m_valid || out_ready));
    @(posedge clk);
    model_edge();
    #1;
    compare_all(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    vt[0]  = '{64'h7000_0000_0000_0000, 1'b1, 3'd1};
    vt[1]  = '{64'h3FFF_0000_0000_0001, 1'b1, 3'd0};
    vt[2]  = '{64'h9400_0000_0000_0000, 1'b1, 3'd2};
    vt[3]  = '{64'hD400_0000_0000_0000, 1'b1, 3'd2};
    vt[4]  = '{64'hB200_0000_1234_5678, 1'b1, 3'd3};
    vt[5]  = '{64'hF200_0000_1234_5678, 1'b1, 3'd0};
    vt[6]  = '{64'hF800_0000_0000_00AA, 1'b0, 3'd4};
    vt[7]  = '{64'hF800_0000_0000_00AA, 1'b1, 3'd0};
    vt[8]  = '{64'hB800_0000_0000_0055, 1'b0, 3'd3};
    vt[9]  = '{64'h8100_0000_0000_0000, 1'b0, 3'd0};
    vt[10] = '{64'hC200_0000_0000_0000, 1'b1, 3'd2};
    vt[11] = '{64'hEB00_0000_0000_0000, 1'b1, 3'd2};

    rst_n = 0; in_valid = 0; in_lv = '0; inst_in = '0; fpu_en = 0;
    out_ready = 1; fault_clr = 0;
    s_in_valid = 0; s_in_lv = 0; s_inst_in = '0; s_fpu_en = 1;
    s_out_ready = 1; s_fault_clr = 0;
    model_reset();
    #12;
    compare_all("reset");
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;

    // Single-lane table vectors on lane 0; other lanes carry junk but are invalid.
    for (int i = 0; i < 12; i++) begin
      in_valid = 1; in_lv = 4'b0001; fpu_en = vt[i].fpu;
      inst_in = {rand_word(), rand_word(), rand_word(), vt[i].inst};
      step($sformatf("tv%0d", i));
      check($sformatf("tv%0d_cause", i), bad_cause[2:0], vt[i].cause);
      check($sformatf("tv%0d_flag", i), bad_op, {3'b000, (vt[i].cause != 3'd0)});
      if (i == 0) begin
        check("tv0_faultInst", fault_inst, 64'h7000_0000_0000_0000);
        check("tv0_badCount", bad_count, 1);
      end
    end

    // Four lanes: ok, bad16, reserved, invalid-but-bad.
    w_a = 64'h8100_0000_0000_0001; w_b = 64'h7123_4567_89AB_CDEF;
    w_c = 64'h9400_0000_0000_0002; w_d = 64'h7000_0000_0000_0003;
    cnt_before = m_cnt;
    in_valid = 1; in_lv = 4'b0111; fpu_en = 1; fault_clr = 1;
    inst_in = {w_d, w_c, w_b, w_a};
    step("quad");
    check("quad_badOpcode", bad_op, 4'b0110);
    check("quad_faultInst", fault_inst, w_b);
    check("quad_faultCause", fault_cause, 3'd1);
    check("quad_count", bad_count, 256'(cnt_before + 2));
    fault_clr = 0;

    // Backpressure: held bundle must not move, counter must not change.
    held = {w_d, w_c, w_b, w_a};
    cnt_before = m_cnt;
    out_ready = 0; in_lv = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      inst_in = {4{64'h9400_0000_0000_0000 | 64'(k)}};
      step($sformatf("hold%0d", k));
      check($sformatf("hold%0d_inReady", k), in_ready, 1'b0);
      check($sformatf("hold%0d_instOut", k), inst_out, held);
      check($sformatf("hold%0d_count", k), bad_count, 256'(cnt_before));
    end
    out_ready = 1;
    for (int k = 0; k < 3; k++) begin
      inst_in = {4{64'h8100_0000_0000_0000 | 64'(k + 16)}};
      held = inst_in;
      step($sformatf("flow%0d", k));
      check($sformatf("flow%0d_instOut", k), inst_out, held);
    end

    // Capture and clear in the same cycle: new word wins.
    in_lv = 4'b0001; fault_clr = 0;
    inst_in = {192'd0, 64'h9400_0000_0000_00A1};
    step("capA");
    fault_clr = 1;
    inst_in = {192'd0, 64'hD400_0000_0000_00B2};
    step("capB");
    check("capB_faultValid", fault_valid, 1'b1);
    check("capB_faultInst", fault_inst, 64'hD400_0000_0000_00B2);
    in_valid = 0;
    step("clr");
    check("clr_faultValid", fault_valid, 1'b0);
    check("clr_faultInst", fault_inst, 64'hD400_0000_0000_00B2);
    fault_clr = 0;

    // Randomised traffic against the model.
    for (int k = 0; k < 400; k++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      fault_clr = ($urandom_range(0, 9) == 0);
      fpu_en    = $urandom_range(0, 1) != 0;
      in_lv     = 4'($urandom_range(0, 15));
      inst_in   = {rand_word(), rand_word(), rand_word(), rand_word()};
      step("rnd");
    end
    out_ready = 1; fault_clr = 0;

    // Reset mid-stream: outputs clear without waiting for a clock edge.
    in_valid = 1; in_lv = 4'b1111;
    inst_in = {4{64'h7000_0000_0000_0000}};
    step("prerst");
    #2 rst_n = 0;
    #1;
    model_reset();
    compare_all("asyncrst");
    @(negedge clk) rst_n = 1;
    in_lv = 4'b0001; inst_in = {192'd0, 64'h9400_0000_0000_0000};
    step("postrst");
    check("postrst_count", bad_count, 1);
    in_valid = 0;

    // Saturation on the 2-bit counter: six bad lanes clamp at 3.
    s_in_valid = 1; s_in_lv = 1; s_inst_in = 64'h7000_0000_0000_0000;
    for (int k = 1; k <= 6; k++) begin
      step("satidle");
      check($sformatf("sat%0d_count", k), s_bad_count, (k < 3) ? k : 3);
    end
    check("sat_flag", s_bad_op, 1'b1);
    check("sat_faultInst", s_fault_inst, 64'h7000_0000_0000_0000);
    s_in_valid = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
